// File: rtl/noise_src_pkg.sv
// Shared types and helpers for the noise_src stimulus generator:
// FSM encoding, Galois LFSR polynomial, 8-step advance and 8-bit saturation.
package noise_src_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    // Right-shifting Galois LFSR: feedback from bit 0 XORs the polynomial mask.
    function automatic logic [31:0] lfsr_step8(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        for (int unsigned i = 0; i < 8; i++) begin
            r = (r >> 1) ^ (r[0] ? LFSR_POLY : '0);
        end
        return r;
    endfunction

    function automatic logic signed [7:0] sat8(input logic signed [9:0] x);
        if (x > 10'sd127) begin
            return 8'h7F;
        end else if (x < -10'sd128) begin
            return 8'h80;
        end else begin
            return x[7:0];
        end
    endfunction

endpackage

// File: rtl/noise_lfsr.sv
// 32-bit Galois LFSR register: synchronous load of a seed, or an 8-step
// advance per cycle when adv is high.
module noise_lfsr
    import noise_src_pkg::*;
#(
    parameter logic [31:0] RST_VAL = 32'h00000001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        adv,
    output logic [31:0] state
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RST_VAL;
        end else if (load) begin
            state <= seed;
        end else if (adv) begin
            state <= lfsr_step8(state);
        end
    end

endmodule

// File: rtl/noise_src.sv
// Pseudo-random, approximately Gaussian signed 8-bit sample source: emits NVL
// samples per start request through a two-stage sum/saturate pipeline.
module noise_src
    import noise_src_pkg::*;
#(
    parameter int unsigned NVL  = 10000,
    parameter logic [31:0] SEED = 32'hACE12468
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              stall_i,
    output logic signed [7:0] data_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned   CW       = $clog2(NVL + 1);
    localparam logic [31:0]   SEED_EFF = (SEED == 32'h0) ? 32'h00000001 : SEED;
    localparam logic [CW-1:0] LAST     = CW'(NVL - 1);

    state_t             state, state_nx;
    logic               load, issue;
    logic [CW-1:0]      cnt;
    logic [31:0]        lfsr;
    logic [9:0]         sum10;
    logic signed [9:0]  s1;
    logic               v1;

    noise_lfsr #(
        .RST_VAL(SEED_EFF)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .seed (SEED_EFF),
        .adv  (issue),
        .state(lfsr)
    );

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        issue    = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nx = RUN;
                    load     = 1'b1;
                end
            end
            RUN: begin
                if (!stall_i) begin
                    issue = 1'b1;
                    if (cnt == LAST) begin
                        state_nx = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (v1) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        sum10 = {{2{lfsr[31]}}, lfsr[31:24]} + {{2{lfsr[23]}}, lfsr[23:16]}
              + {{2{lfsr[15]}}, lfsr[15:8]}  + {{2{lfsr[7]}},  lfsr[7:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (load) begin
                cnt <= '0;
            end else if (issue) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= issue;
            if (issue) begin
                s1 <= sum10;
            end
        end
    end

    // busy/done are registered from the FSM so they line up with the
    // two-stage data path: busy covers every valid cycle, done follows the last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_o  <= '0;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            valid_o <= v1;
            if (v1) begin
                data_o <= sat8(s1 >>> 1);
            end
            busy_o <= (state_nx == RUN) || (state_nx == FLUSH) || (state_nx == DONE);
            done_o <= (state == DONE);
        end
    end

endmodule

// File: tb/tb_noise_src.sv
// Scoreboard bench for noise_src: stimulus pushes expected samples/done times,
// a negedge monitor pops and compares against a behavioural reference model.
module tb_noise_src;

    localparam int unsigned NVL_M  = 10;
    localparam logic [31:0] SEED_M = 32'hACE12468;
    localparam int          NS     = 6;
    localparam logic [31:0] SEEDS [NS] = '{32'hACE12468, 32'h01020304, 32'hFFFFFFFF,
                                           32'h7F7F7F7F, 32'h80808080, 32'h00000000};
    localparam int unsigned NVLS  [NS] = '{4, 4, 4, 4, 4, 1};
    localparam int          FIRSTS[NS] = '{12, 5, -2, 127, -128, 0};

    typedef struct {
        int data;
        int at;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              start_i;
    logic              stall_i;
    logic              start_b;
    logic signed [7:0] data_o;
    logic              valid_o;
    logic              busy_o;
    logic              done_o;
    logic              small_end;

    int   checks;
    int   errors;
    int   cyc;
    int   s0_b;
    exp_t sq[$];
    int   dq[$];
    exp_t cur;
    int   exp_seq[NVL_M];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    noise_src #(
        .NVL (NVL_M),
        .SEED(SEED_M)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .start_i(start_i),
        .stall_i(stall_i),
        .data_o (data_o),
        .valid_o(valid_o),
        .busy_o (busy_o),
        .done_o (done_o)
    );

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, got, want, cyc);
        end
    endtask

    // Reference: plain bit-serial LFSR, integer byte sum, floor-halve, clamp.
    function automatic logic [31:0] ref_adv(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        for (int k = 0; k < 8; k++) begin
            if (r[0]) r = (r >> 1) ^ 32'h80200003;
            else      r = r >> 1;
        end
        return r;
    endfunction

    function automatic int ref_sample(input logic [31:0] seed, input int idx);
        logic [31:0] r;
        int s;
        int h;
        byte sb;
        r = (seed == 32'h0) ? 32'h1 : seed;
        for (int k = 0; k < idx; k++) r = ref_adv(r);
        s = 0;
        for (int b = 0; b < 4; b++) begin
            sb = byte'(r >> (8 * b));
            s += int'(sb);
        end
        h = (s >= 0) ? s / 2 : -((1 - s) / 2);
        if (h > 127)  h = 127;
        if (h < -128) h = -128;
        return h;
    endfunction

    always @(negedge clk) begin
        if (valid_o) begin
            if (sq.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                cur = sq.pop_front();
                chk("sample_data", int'(data_o), cur.data);
                chk("sample_cycle", cyc, cur.at);
                chk("busy_with_valid", int'(busy_o), 1);
            end
        end
        if (done_o) begin
            if (dq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                chk("done_cycle", cyc, dq.pop_front());
                chk("done_valid_low", int'(valid_o), 0);
                chk("done_busy_low", int'(busy_o), 0);
            end
        end
    end

    for (genvar g = 0; g < NS; g++) begin : g_small
        logic signed [7:0] d;
        logic              v;
        logic              b;
        logic              dn;
        int                nv = 0;
        int                nd = 0;

        noise_src #(
            .NVL (NVLS[g]),
            .SEED(SEEDS[g])
        ) u_small (
            .clk    (clk),
            .rst    (rst),
            .start_i(start_b),
            .stall_i(1'b0),
            .data_o (d),
            .valid_o(v),
            .busy_o (b),
            .done_o (dn)
        );

        always @(negedge clk) begin
            if (v) begin
                chk("small_data", int'(d), ref_sample(SEEDS[g], nv));
                chk("small_cycle", cyc, s0_b + 2 + nv);
                chk("small_busy", int'(b), 1);
                if (nv == 0) chk("small_first", int'(d), FIRSTS[g]);
                nv++;
            end
            if (dn) begin
                nd++;
                chk("small_done_cycle", cyc, s0_b + 2 + int'(NVLS[g]));
            end
        end

        initial begin
            wait (small_end);
            chk("small_valid_count", nv, int'(NVLS[g]));
            chk("small_done_count", nd, 1);
        end
    end

    // mode 0: no stall, 1: alternating stall, 2: random stall (+ start noise in RUN)
    task automatic run(input int mode, input bit hold);
        int n;
        bit st;
        n = 0;
        start_i = 1'b1;
        @(posedge clk); #1;
        if (!hold) start_i = 1'b0;
        chk("busy_after_start", int'(busy_o), 1);
        for (int k = 0; k < 200 && n < int'(NVL_M); k++) begin
            case (mode)
                0:       st = 1'b0;
                1:       st = (k % 2 == 0);
                default: st = ($urandom_range(0, 2) == 0);
            endcase
            stall_i = st;
            if (mode == 2 && !hold) start_i = ($urandom_range(0, 1) == 1);
            @(posedge clk); #1;
            if (!st) begin
                sq.push_back('{exp_seq[n], cyc + 1});
                n++;
                if (n == int'(NVL_M)) dq.push_back(cyc + 2);
            end
        end
        stall_i = 1'b0;
        if (!hold) start_i = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
    endtask

    task automatic reset_mid();
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            stall_i = 1'b0;
            @(posedge clk); #1;
            sq.push_back('{exp_seq[k], cyc + 1});
        end
        rst = 1'b1;
        sq.delete();
        dq.delete();
        #1;
        chk("rst_mid_data", int'(data_o), 0);
        chk("rst_mid_valid", int'(valid_o), 0);
        chk("rst_mid_busy", int'(busy_o), 0);
        chk("rst_mid_done", int'(done_o), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        start_i   = 1'b0;
        stall_i   = 1'b0;
        start_b   = 1'b0;
        small_end = 1'b0;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        s0_b      = 0;
        for (int i = 0; i < int'(NVL_M); i++) exp_seq[i] = ref_sample(SEED_M, i);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_data", int'(data_o), 0);
        chk("reset_valid", int'(valid_o), 0);
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_done", int'(done_o), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        s0_b = cyc;
        repeat (12) @(posedge clk);
        #1;
        small_end = 1'b1;
        @(posedge clk); #1;

        run(0, 1'b0);
        run(1, 1'b0);
        run(2, 1'b0);
        reset_mid();
        run(2, 1'b1);
        run(0, 1'b1);
        run(1, 1'b1);
        start_i = 1'b0;

        repeat (6) @(posedge clk);
        #1;
        chk("pending_samples", sq.size(), 0);
        chk("pending_done", dq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/noise_src.md
# noise_src

Hardware stimulus source producing a pseudo-random, approximately Gaussian stream of signed 8-bit samples with a valid strobe, matching the `data_i`/`valid_i` input of the 17-tap FIR (`fir_17`). On a start request it emits exactly NVL samples, then signals completion. It replaces file-driven noise stimulus for on-chip and self-checking filter tests.

## Interface
- `NVL`, 10000 — samples emitted per run; must be ≥ 1.
- `SEED`, 32'hACE12468 — LFSR load value at each start. A value of 0 is replaced by 32'h00000001.
- `CW`, localparam `$clog2(NVL+1)` — sample counter width.

- `clk`  in  1  — clock; all state is updated on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `start_i`  in  1  — begins a run; sampled only in IDLE; ignored in all other states.
- `stall_i`  in  1  — while high in RUN, no sample is issued.
- `data_o`  out  8 signed  — noise sample, registered.
- `valid_o`  out  1  — `data_o` is a new sample this cycle; registered.
- `busy_o`  out  1  — high in RUN and FLUSH.
- `done_o`  out  1  — one-cycle pulse at the end of a run.

## Operation
- **LFSR:** 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (mask 32'h80200003). Each issue advances it 8 steps in one cycle.
- **Issue (RUN, `stall_i`=0):**
  - Stage-1 sum `s1` (10-bit signed) ← sum of the current LFSR's four bytes, each as signed 8-bit.
  - `v1` ← 1; LFSR ← step8(LFSR); counter increments.
  - In stalled cycles `v1` ← 0, and LFSR and counter hold.
- **Stage 2 (every cycle):**
  - `data_o` ← sat8(`s1` >>> 1), where >>> is an arithmetic shift (floor, e.g. −3 → −2).
  - sat8 clamps to [−128, 127].
  - `valid_o` ← `v1`.
  - When `v1`=0, `data_o` holds its previous value.
- **FSM:**
  - IDLE: on `start_i`, go to RUN; LFSR ← SEED; counter ← 0; `v1` ← 0.
  - RUN: issue per the rule above. The issue that produces sample NVL moves the FSM to FLUSH.
  - FLUSH: no issue. Move to DONE on the edge where the final sample is registered into `data_o`.
  - DONE: `done_o`=1 for this cycle only; go to IDLE unconditionally.
- The first sample of a run is derived from SEED itself.
- **Reset values:** `data_o`=0, `valid_o`=0, `busy_o`=0, `done_o`=0, FSM=IDLE, `s1`=0, `v1`=0, counter=0, LFSR=SEED.
- **Reset mid-run** aborts immediately with no `done_o`. A later start replays the identical sequence.
- **`start_i` held high** through DONE starts a new run from the IDLE cycle that follows, reloading SEED.

## Timing
- Let the start edge be edge 0 (IDLE, `start_i`=1).
  - RUN begins at cycle 1; first issue at edge 1.
  - First `valid_o`=1 during cycle 3.
  - Issue-to-output latency is 2 cycles.
- Without stalls, `valid_o` is high on cycles 3 … NVL+2 and `done_o` is high on cycle NVL+3.
- Each stalled RUN cycle inserts a `valid_o`=0 gap two cycles later and delays `done_o` by one cycle.
- `done_o` is always the cycle directly after the last `valid_o`.
- `busy_o` is high from cycle 1 through the last `valid_o` cycle.
- Total `valid_o` pulses per run equal exactly NVL, regardless of the stall pattern.
- **NVL=1:** single issue at edge 1, FLUSH at cycle 2, `valid_o` at cycle 3, `done_o` at cycle 4.

## Structure
- Package `noise_src_pkg` holds:
  - FSM state encoding (IDLE, RUN, FLUSH, DONE);
  - `LFSR_POLY` = 32'h80200003;
  - function `lfsr_step8`;
  - function `sat8` (10-bit signed → 8-bit signed).
- One sub-module `noise_lfsr`: LFSR register with `load`/`seed` and `adv` (8-step advance) inputs; outputs the current 32-bit state.
- Sum, saturation pipeline, counter and FSM live in `noise_src`.

## Test plan
- **Default seed:** SEED=32'hACE12468, NVL=4, no stall → first `data_o`=12 (−84−31+36+104=25 → 12) on cycle 3. Exactly 4 valids, `done_o` on cycle 7.
- **Positive rounding:** SEED=32'h01020304 → first sample 5. SEED=32'hFFFFFFFF → sum −4 → −2.
- **Saturation:** SEED=32'h7F7F7F7F → 127 (254 clamped). SEED=32'h80808080 → −128 (−256 clamped).
- **Stall pattern:** NVL=10, `stall_i` high on alternating RUN cycles → 10 valids, values identical to the unstalled run, gaps 2 cycles after each stall. `done_o` on the cycle after the 10th valid.
- **Reset mid-run:** `rst` pulse at cycle 5 → all outputs 0 the same cycle, no `done_o`. Restart reproduces the sequence from the first sample.
- **Start handling:** `start_i` asserted during RUN → ignored, count unchanged. `start_i` held continuously → back-to-back runs with identical sequences, each ending in a single `done_o` pulse. The bench compares all samples against a reference model of `lfsr_step8` and `sat8`.
